// File: rtl/inst_fetcher_pkg.sv
// Shared constants and types for the instruction fetch stage and its I-cache.
package inst_fetcher_pkg;

    localparam int InstWidth = 32;
    localparam int AddrWidth = 32;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    localparam logic [6:0] OPCODE_BR  = 7'b1100011;

    typedef enum logic {
        IDLE      = 1'b0,
        MISS_WAIT = 1'b1
    } fetch_state_e;

    function automatic logic [AddrWidth-1:0] imm_j(input logic [InstWidth-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [AddrWidth-1:0] imm_b(input logic [InstWidth-1:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup, single write port.
module icache_dm
    import inst_fetcher_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AddrWidth-1:0] i_rd_addr,
    output logic                 o_hit,
    output logic [InstWidth-1:0] o_rd_data,
    input  logic                 i_wr_en,
    input  logic [AddrWidth-1:0] i_wr_addr,
    input  logic [InstWidth-1:0] i_wr_data
);

    localparam int Lines = 1 << IDX_W;
    localparam int TagW  = AddrWidth - IDX_W - 2;

    logic [Lines-1:0]     r_valid;
    logic [TagW-1:0]      r_tag  [Lines];
    logic [InstWidth-1:0] r_data [Lines];

    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [TagW-1:0]  w_rd_tag;
    logic [TagW-1:0]  w_wr_tag;
    logic             w_unused;

    assign w_rd_idx = i_rd_addr[IDX_W+1:2];
    assign w_rd_tag = i_rd_addr[AddrWidth-1:IDX_W+2];
    assign w_wr_idx = i_wr_addr[IDX_W+1:2];
    assign w_wr_tag = i_wr_addr[AddrWidth-1:IDX_W+2];
    assign w_unused = ^{i_rd_addr[1:0], i_wr_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[w_wr_idx] <= True;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[w_wr_idx]  <= w_wr_tag;
            r_data[w_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    assign o_rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: holds the PC, looks up the I-cache, refills on miss, predicts and pushes to the IQ.
// Define INST_FETCHER_BHT_EN to predict conditional branches with a 2-bit saturating counter table.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int                   ICACHE_IDX_W = 6,
    parameter int                   BHT_IDX_W    = 6,
    parameter logic [AddrWidth-1:0] RESET_PC     = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 IQ_is_full,
    output logic                 IQ_output_valid,
    output logic [InstWidth-1:0] IQ_inst,
    output logic [AddrWidth-1:0] IQ_inst_pc,
    output logic                 IQ_predicted_to_jump,
    output logic [AddrWidth-1:0] IQ_predicted_pc,
    output logic                 MC_req_valid,
    output logic [AddrWidth-1:0] MC_req_addr,
    input  logic                 MC_resp_valid,
    input  logic [InstWidth-1:0] MC_resp_inst,
    input  logic                 ROB_roll_back_flag,
    input  logic [AddrWidth-1:0] ROB_roll_back_pc,
    input  logic                 ROB_br_commit_valid,
    input  logic [AddrWidth-1:0] ROB_br_pc,
    input  logic                 ROB_br_taken
);

    fetch_state_e         r_state;
    logic [AddrWidth-1:0] r_pc;
    logic                 r_iq_valid;
    logic [InstWidth-1:0] r_iq_inst;
    logic [AddrWidth-1:0] r_iq_pc;
    logic                 r_iq_jump;
    logic [AddrWidth-1:0] r_iq_ppc;
    logic                 r_mc_req;
    logic [AddrWidth-1:0] r_mc_addr;

    logic                 w_hit;
    logic [InstWidth-1:0] w_word;
    logic                 w_fill;
    logic [AddrWidth-1:0] w_imm_j;
    logic [AddrWidth-1:0] w_imm_b;
    logic                 w_br_taken;
    logic                 w_pred_taken;
    logic [AddrWidth-1:0] w_pred_pc;

    // A response in a roll-back or stalled cycle must not reach the cache.
    assign w_fill = rdy && !ROB_roll_back_flag && (r_state == MISS_WAIT) && MC_resp_valid;

    icache_dm #(.IDX_W(ICACHE_IDX_W)) u_icache (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (r_pc),
        .o_hit     (w_hit),
        .o_rd_data (w_word),
        .i_wr_en   (w_fill),
        .i_wr_addr (r_pc),
        .i_wr_data (MC_resp_inst)
    );

    assign w_imm_j = imm_j(w_word);
    assign w_imm_b = imm_b(w_word);

`ifdef INST_FETCHER_BHT_EN
    localparam int BhtEntries = 1 << BHT_IDX_W;

    logic [1:0]           r_bht [BhtEntries];
    logic [BHT_IDX_W-1:0] w_bht_wr_idx;
    logic                 w_unused;

    assign w_bht_wr_idx = ROB_br_pc[BHT_IDX_W+1:2];
    assign w_unused     = ^{ROB_br_pc[AddrWidth-1:BHT_IDX_W+2], ROB_br_pc[1:0]};
    assign w_br_taken   = r_bht[r_pc[BHT_IDX_W+1:2]][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BhtEntries; i++) r_bht[i] <= 2'b01;
        end else if (rdy && ROB_br_commit_valid) begin
            if (ROB_br_taken && r_bht[w_bht_wr_idx] != 2'b11)
                r_bht[w_bht_wr_idx] <= r_bht[w_bht_wr_idx] + 2'd1;
            else if (!ROB_br_taken && r_bht[w_bht_wr_idx] != 2'b00)
                r_bht[w_bht_wr_idx] <= r_bht[w_bht_wr_idx] - 2'd1;
        end
    end
`else
    logic                 w_unused;
    logic [BHT_IDX_W-1:0] w_unused_bht_idx;

    assign w_unused         = ^{ROB_br_commit_valid, ROB_br_taken, ROB_br_pc};
    assign w_unused_bht_idx = ROB_br_pc[BHT_IDX_W+1:2];
    // Backward branches (negative offset) are predicted taken.
    assign w_br_taken       = w_imm_b[AddrWidth-1];
`endif

    always_comb begin
        w_pred_taken = False;
        w_pred_pc    = r_pc + 32'd4;
        if (w_word[6:0] == OPCODE_JAL) begin
            w_pred_taken = True;
            w_pred_pc    = r_pc + w_imm_j;
        end else if (w_word[6:0] == OPCODE_BR && w_br_taken) begin
            w_pred_taken = True;
            w_pred_pc    = r_pc + w_imm_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_iq_valid <= False;
            r_iq_inst  <= '0;
            r_iq_pc    <= '0;
            r_iq_jump  <= False;
            r_iq_ppc   <= '0;
            r_mc_req   <= False;
            r_mc_addr  <= '0;
        end else if (rdy) begin
            if (ROB_roll_back_flag) begin
                r_pc       <= ROB_roll_back_pc;
                r_iq_valid <= False;
                r_mc_req   <= False;
                r_state    <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_hit) begin
                            r_iq_valid <= !IQ_is_full;
                            if (!IQ_is_full) begin
                                r_iq_inst <= w_word;
                                r_iq_pc   <= r_pc;
                                r_iq_jump <= w_pred_taken;
                                r_iq_ppc  <= w_pred_pc;
                                r_pc      <= w_pred_pc;
                            end
                        end else begin
                            r_iq_valid <= False;
                            r_mc_req   <= True;
                            r_mc_addr  <= r_pc;
                            r_state    <= MISS_WAIT;
                        end
                    end
                    MISS_WAIT: begin
                        r_iq_valid <= False;
                        if (MC_resp_valid) begin
                            r_mc_req <= False;
                            r_state  <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign IQ_output_valid      = r_iq_valid;
    assign IQ_inst              = r_iq_inst;
    assign IQ_inst_pc           = r_iq_pc;
    assign IQ_predicted_to_jump = r_iq_jump;
    assign IQ_predicted_pc      = r_iq_ppc;
    assign MC_req_valid         = r_mc_req;
    assign MC_req_addr          = r_mc_addr;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios plus randomized stalls/roll-backs against a stream model.
module tb_inst_fetcher;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, rdy, IQ_is_full;
    logic        IQ_output_valid, IQ_predicted_to_jump, MC_req_valid, MC_resp_valid;
    logic [31:0] IQ_inst, IQ_inst_pc, IQ_predicted_pc, MC_req_addr, MC_resp_inst;
    logic        ROB_roll_back_flag, ROB_br_commit_valid, ROB_br_taken;
    logic [31:0] ROB_roll_back_pc, ROB_br_pc;

    always #5 clk = ~clk;

    inst_fetcher #(.ICACHE_IDX_W(6), .BHT_IDX_W(6), .RESET_PC(32'h0)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .IQ_is_full           (IQ_is_full),
        .IQ_output_valid      (IQ_output_valid),
        .IQ_inst              (IQ_inst),
        .IQ_inst_pc           (IQ_inst_pc),
        .IQ_predicted_to_jump (IQ_predicted_to_jump),
        .IQ_predicted_pc      (IQ_predicted_pc),
        .MC_req_valid         (MC_req_valid),
        .MC_req_addr          (MC_req_addr),
        .MC_resp_valid        (MC_resp_valid),
        .MC_resp_inst         (MC_resp_inst),
        .ROB_roll_back_flag   (ROB_roll_back_flag),
        .ROB_roll_back_pc     (ROB_roll_back_pc),
        .ROB_br_commit_valid  (ROB_br_commit_valid),
        .ROB_br_pc            (ROB_br_pc),
        .ROB_br_taken         (ROB_br_taken)
    );

    int vectors = 0;
    int errors  = 0;
    int pushes  = 0;

    logic [31:0] mem [logic [31:0]];
    int          bht [64];

    // Model state: expected fetch PC and the memory controller's pending request
    logic [31:0] exp_pc;
    bit          pend;
    int          cnt;
    int          lat;
    logic [31:0] pend_addr;
    bit          force_resp;

    logic        last_jump;
    logic [31:0] last_pc, last_ppc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : NOP;
    endfunction

    function automatic void predict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
        logic [31:0] w;
        int          imm;
        w   = memrd(pc);
        tk  = 0;
        tgt = pc + 4;
        if (w[6:0] == 7'b1101111) begin
            imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            tk  = 1;
            tgt = pc + imm;
        end else if (w[6:0] == 7'b1100011) begin
            imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
`ifdef INST_FETCHER_BHT_EN
            tk = (bht[pc[7:2]] >= 2);
`else
            tk = (imm < 0);
`endif
            if (tk) tgt = pc + imm;
        end
    endfunction

    function automatic logic [31:0] enc_jal(input int imm);
        logic [20:0] i;
        i = imm[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_beq(input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd1, 5'd2, 3'd0, i[4:1], i[11], 7'b1100011};
    endfunction

    // One clock: drive memory response, clock, then check outputs against the stream model.
    task automatic tick();
        bit          ptk, rdy_now, rst_now, rb_now, full_now, resp_now, cmt_now, cmt_tk;
        logic [31:0] ptgt, rb_target, cmt_pc;
        logic        s_valid, s_jump, s_req;
        logic [31:0] s_inst, s_pc, s_ppc, s_addr;

        predict(exp_pc, ptk, ptgt);
        MC_resp_valid = 1'b0;
        MC_resp_inst  = $urandom;
        if (force_resp) begin
            MC_resp_valid = 1'b1;
        end else if (rdy && pend && !ROB_roll_back_flag) begin
            if (cnt == 0) begin
                MC_resp_valid = 1'b1;
                MC_resp_inst  = memrd(pend_addr);
                pend          = 0;
            end else begin
                cnt--;
            end
        end
        if (rdy && ROB_roll_back_flag) pend = 0;

        rdy_now = rdy;  rst_now = rst;  rb_now = ROB_roll_back_flag;  rb_target = ROB_roll_back_pc;
        full_now = IQ_is_full;  resp_now = MC_resp_valid;
        cmt_now = ROB_br_commit_valid;  cmt_tk = ROB_br_taken;  cmt_pc = ROB_br_pc;
        s_valid = IQ_output_valid;  s_jump = IQ_predicted_to_jump;  s_req = MC_req_valid;
        s_inst = IQ_inst;  s_pc = IQ_inst_pc;  s_ppc = IQ_predicted_pc;  s_addr = MC_req_addr;

        @(posedge clk);
        #1;

        if (rst_now) begin
            exp_pc = 32'h0;
            pend   = 0;
            for (int i = 0; i < 64; i++) bht[i] = 1;
        end else if (!rdy_now) begin
            chk("hold_valid", IQ_output_valid, s_valid);
            chk("hold_inst_pc", IQ_inst_pc, s_pc);
            chk("hold_inst", IQ_inst, s_inst);
            chk("hold_ppc", IQ_predicted_pc, s_ppc);
            chk("hold_jump", IQ_predicted_to_jump, s_jump);
            chk("hold_req", MC_req_valid, s_req);
            chk("hold_addr", MC_req_addr, s_addr);
        end else begin
            if (cmt_now) begin
                if (cmt_tk) bht[cmt_pc[7:2]] = (bht[cmt_pc[7:2]] == 3) ? 3 : bht[cmt_pc[7:2]] + 1;
                else        bht[cmt_pc[7:2]] = (bht[cmt_pc[7:2]] == 0) ? 0 : bht[cmt_pc[7:2]] - 1;
            end
            if (rb_now) begin
                chk("rb_no_push", IQ_output_valid, 0);
                chk("rb_req_drop", MC_req_valid, 0);
                exp_pc = rb_target;
            end else begin
                if (resp_now) chk("fill_no_push", IQ_output_valid, 0);
                if (IQ_output_valid) begin
                    chk("push_while_full", full_now, 0);
                    chk("push_pc", IQ_inst_pc, exp_pc);
                    chk("push_inst", IQ_inst, memrd(exp_pc));
                    chk("push_jump", IQ_predicted_to_jump, ptk);
                    chk("push_ppc", IQ_predicted_pc, ptgt);
                    last_pc = IQ_inst_pc;  last_ppc = IQ_predicted_pc;  last_jump = IQ_predicted_to_jump;
                    exp_pc = ptgt;
                    pushes++;
                end
            end
            if (MC_req_valid) chk("req_addr", MC_req_addr, exp_pc);
            if (MC_req_valid && !pend) begin
                pend = 1;  pend_addr = MC_req_addr;  cnt = lat;
            end
        end
    endtask

    task automatic wait_push();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rdy && IQ_output_valid) break;
        end
        chk("wait_push", IQ_output_valid, 1);
    endtask

    task automatic rollback(input logic [31:0] target);
        ROB_roll_back_flag = 1'b1;
        ROB_roll_back_pc   = target;
        tick();
        ROB_roll_back_flag = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input bit taken);
        ROB_br_commit_valid = 1'b1;
        ROB_br_pc           = pc;
        ROB_br_taken        = taken;
        tick();
        ROB_br_commit_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] loop_pc [4];
        logic [31:0] rw;
        int          off;

        rst = 1'b1;  rdy = 1'b1;  IQ_is_full = 1'b0;
        MC_resp_valid = 1'b0;  MC_resp_inst = '0;
        ROB_roll_back_flag = 1'b0;  ROB_roll_back_pc = '0;
        ROB_br_commit_valid = 1'b0;  ROB_br_pc = '0;  ROB_br_taken = 1'b0;
        exp_pc = 0;  pend = 0;  cnt = 0;  lat = 3;  force_resp = 0;
        pend_addr = 0;  last_pc = 0;  last_ppc = 0;  last_jump = 0;
        loop_pc[0] = 32'h0;  loop_pc[1] = 32'h4;  loop_pc[2] = 32'h8;  loop_pc[3] = 32'h0;

        mem[32'h8]  = 32'hFF9FF06F;  // jal x0,-8
        mem[32'h10] = 32'h00000863;  // beq +16
        mem[32'h90] = 32'hFE0008E3;  // beq -16
        for (int a = 0; a < 256; a++) begin
            rw  = $urandom;
            off = 4 * (int'($urandom_range(0, 64)) - 32);
            case ($urandom_range(0, 3))
                0:       mem[32'h400 + 4 * a] = NOP;
                1:       mem[32'h400 + 4 * a] = enc_jal(off);
                2:       mem[32'h400 + 4 * a] = enc_beq(off);
                default: mem[32'h400 + 4 * a] = {rw[31:7], 7'b0010011};
            endcase
        end

        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", IQ_output_valid, 0);
        chk("reset_req", MC_req_valid, 0);
        chk("reset_addr", MC_req_addr, 0);
        chk("reset_inst", IQ_inst, 0);
        chk("reset_pc", IQ_inst_pc, 0);
        chk("reset_jump", IQ_predicted_to_jump, 0);
        chk("reset_ppc", IQ_predicted_pc, 0);

        // Cold start
        tick();
        chk("first_req", MC_req_valid, 1);
        chk("first_addr", MC_req_addr, 32'h0);
        wait_push();
        chk("p0_pc", last_pc, 32'h0);
        chk("p0_ppc", last_ppc, 32'h4);
        wait_push();
        chk("p1_pc", last_pc, 32'h4);
        chk("p1_ppc", last_ppc, 32'h8);

        // Warm loop 0,4,8 back to 0 with the jump predicted
        wait_push();
        chk("j8_pc", last_pc, 32'h8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("loop_valid", IQ_output_valid, 1);
            chk("loop_pc", IQ_inst_pc, loop_pc[i]);
        end
        chk("loop_jump_prev", last_jump, 0);
        chk("loop_j8_ppc", IQ_predicted_pc, 32'h4);

        // Queue full for 5 cycles mid-loop
        IQ_is_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_no_push", IQ_output_valid, 0);
        end
        IQ_is_full = 1'b0;
        tick();
        chk("full_resume_valid", IQ_output_valid, 1);
        chk("full_resume_pc", IQ_inst_pc, 32'h4);
        tick();
        chk("loop8_jump", IQ_predicted_to_jump, 1);
        chk("loop8_ppc", IQ_predicted_pc, 32'h0);

        // Global stall mid-stream
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rdy = 1'b1;
        tick();
        chk("stall_resume_valid", IQ_output_valid, 1);
        chk("stall_resume_pc", IQ_inst_pc, 32'h0);

        // Conditional branches
        rollback(32'h10);
        wait_push();
        chk("beq_fwd_jump", last_jump, 0);
        chk("beq_fwd_ppc", last_ppc, 32'h14);
        rollback(32'h90);
        wait_push();
`ifdef INST_FETCHER_BHT_EN
        chk("beq_back_jump", last_jump, 0);
        chk("beq_back_ppc", last_ppc, 32'h94);
        commit(32'h90, 1);
        commit(32'h90, 1);
        rollback(32'h90);
        wait_push();
        chk("bht_taken_jump", last_jump, 1);
        chk("bht_taken_ppc", last_ppc, 32'h80);
        commit(32'h90, 0);
        commit(32'h90, 0);
        rollback(32'h90);
        wait_push();
        chk("bht_nt_jump", last_jump, 0);
        chk("bht_nt_ppc", last_ppc, 32'h94);
`else
        chk("beq_back_jump", last_jump, 1);
        chk("beq_back_ppc", last_ppc, 32'h80);
`endif

        // Roll back while waiting on a miss, with a same-cycle response
        rollback(32'h3C0);
        tick();
        chk("miss_req", MC_req_valid, 1);
        force_resp = 1;
        rollback(32'h100);
        force_resp = 0;
        tick();
        chk("redirect_req", MC_req_valid, 1);
        chk("redirect_addr", MC_req_addr, 32'h100);
        wait_push();
        chk("redirect_push_pc", last_pc, 32'h100);
        rollback(32'h3C0);
        tick();
        chk("discard_miss_req", MC_req_valid, 1);
        chk("discard_miss_addr", MC_req_addr, 32'h3C0);

        // Randomized stalls, queue back-pressure, latency, roll-backs and commits
        rollback(32'h400);
        pushes = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy                 = ($urandom_range(0, 9) != 0);
            IQ_is_full          = ($urandom_range(0, 3) == 0);
            lat                 = $urandom_range(0, 4);
            ROB_roll_back_flag  = ($urandom_range(0, 39) == 0);
            ROB_roll_back_pc    = 32'h400 + 4 * $urandom_range(0, 255);
            ROB_br_commit_valid = ($urandom_range(0, 4) == 0);
            ROB_br_pc           = 32'h400 + 4 * $urandom_range(0, 255);
            ROB_br_taken        = $urandom_range(0, 1) == 1;
            tick();
        end
        chk("random_progress", (pushes > 300) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
